minterm_lut_decoder: RTL and testbench
======================================

Name: minterm_lut_decoder

Overview:
- Parametrised, pipelined sum-of-minterms function unit. An N-to-2^N one-hot decoder feeds an OR-reduction over a programmable minterm mask.
- Replaces fixed decoder-plus-OR gate expressions. Any N-input Boolean function can be loaded at run time, in parallel or serially, with valid-qualified 2-cycle latency.
- Used wherever small SOP logic functions must be reconfigurable without resynthesis.

Parameters:
- N, 3, number of select inputs; legal range 1..6; decoder width W = 2^N.
- INIT_MASK, 'h72, reset value of the active mask; zero-extended or truncated to W bits. 'h72 = minterms 1,4,5,6 for N=3, i.e. a(~b) + ab(~c) + (~b)c with a as MSB.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sel_in is valid this cycle.
- sel_in  input  N  function inputs; bit N-1 is the MSB (a).
- cfg_we  input  1  parallel mask write strobe.
- cfg_data  input  W  parallel mask value; bit k = minterm k.
- cfg_shift_en  input  1  serial load strobe; one bit per cycle.
- cfg_sdi  input  1  serial mask bit, LSB (minterm 0) first.
- dec_out  output  W  registered one-hot decode (stage 1).
- dec_valid  output  1  dec_out is valid.
- y  output  1  registered function result (stage 2).
- y_valid  output  1  y is valid.
- cfg_done  output  1  one-cycle pulse when a new mask becomes active.
- mask_out  output  W  current active mask, for readback.

Behaviour:
- Reset (async assert, sync release): dec_out=0, dec_valid=0, y=0, y_valid=0, cfg_done=0, active mask=INIT_MASK, shadow=0, bit counter=0.
- Stage 1 (cycle after in_valid=1):
  - dec_out = 1<<sel_in; dec_valid=1.
  - The active mask sampled in the accept cycle is captured alongside dec_out as a per-transaction mask copy.
- When in_valid=0, stage 1 loads dec_out=0 and dec_valid=0.
- Stage 2 (one cycle after stage 1):
  - y = |(dec_out_s1 & mask_copy_s1); y_valid = dec_valid.
  - y=0 whenever y_valid=0.
- Latency is 2 cycles from in_valid to y_valid. Throughput is 1 per cycle with no stalls and no back-pressure.
- Parallel config: cfg_we=1 means active mask <= cfg_data at the edge, cfg_done=1 next cycle, bit counter <= 0, shadow <= 0.
- Serial config:
  - Each cycle with cfg_shift_en=1, shadow <= {cfg_sdi, shadow[W-1:1]} and the counter increments.
  - On the shift that brings the counter to W, the committed mask is the shifted shadow value including that bit. Active mask <= that value, cfg_done pulses next cycle, and the counter wraps to 0.
- cfg_we and cfg_shift_en both high: cfg_we wins and the shift is discarded.
- Mask change and in_valid in the same cycle: the input uses the old mask, and the next accepted input uses the new one. Transactions already in flight are never affected by a later mask change.
- Counter width is N+1 bits. A partial serial load (counter < W) never alters the active mask.
- Reset mid-operation clears the pipeline, the shadow and a partial serial load. In-flight results are lost, and the mask returns to INIT_MASK.
- mask_out is combinationally equal to the active mask register.

Decomposition:
- Shared package holds:
  - the N-to-W width function (W = 1<<N);
  - the default mask constant for N=3 ('h72);
  - a counter-width helper (N+1).
- One natural sub-module: decoder_n, a parametrised N-to-2^N combinational one-hot decoder with enable. It is instantiated in stage 1; registers stay in the parent.

Test Plan:
- Reset defaults: hold rst_n=0 for 3 cycles, release -> all outputs 0 and mask_out='h72. Assert rst_n=0 asynchronously mid-cycle -> outputs clear before the next edge.
- Exhaustive default sweep: sel_in=0..7, back-to-back with in_valid=1 -> y_valid stream 2 cycles later, y = 0,1,0,0,1,1,1,0; dec_out one-hot 'h01..'h80 one cycle after each input.
- Parallel write: cfg_we with cfg_data='h81, then sweep 0..7 -> y=1 only for sel_in 0 and 7; cfg_done pulses once.
- Serial load: shift bits 1,0,0,0,0,0,0,1 then 0,1,... -> after the 8th bit cfg_done pulses and mask_out='h81. Stop after 5 bits -> mask unchanged.
- Simultaneous events:
  - cfg_we='h00 in the same cycle as in_valid, sel_in=1 -> that y=1 (old mask); the next input with sel_in=1 gives y=0.
  - cfg_we and cfg_shift_en together -> parallel value wins and the counter resets.
- Parameter sweep: N=1 and N=5 with random masks and random in_valid gaps -> y matches a scoreboard model; dec_valid and y_valid gaps are preserved exactly.

Source files
------------

// File: rtl/minterm_lut_decoder_pkg.sv
// Shared definitions for the programmable sum-of-minterms unit.
//   dec_width(n) : decoder output width for n select inputs (2^n)
//   cnt_width(n) : serial-load bit counter width (n+1, so it can count to 2^n)
//   DEFAULT_MASK_N3 : a(~b) + ab(~c) + (~b)c for N=3 (minterms 1,4,5,6)
package minterm_lut_decoder_pkg;

  localparam int          N_MIN           = 1;
  localparam int          N_MAX           = 6;
  localparam logic [63:0] DEFAULT_MASK_N3 = 64'h72;

  function automatic int dec_width(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/minterm_lut_decoder_decoder_n.sv
// Combinational N-to-2^N one-hot decoder with enable.
//   en_i     : when low the output is all zeros
//   sel_i    : binary select, bit N-1 is the MSB
//   onehot_o : bit sel_i set when enabled
module decoder_n
  import minterm_lut_decoder_pkg::*;
#(
  parameter int  N = 3,
  localparam int W = dec_width(N)
) (
  input  logic         en_i,
  input  logic [N-1:0] sel_i,
  output logic [W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = W'(1) << sel_i;
    end
  end

endmodule

// File: rtl/minterm_lut_decoder.sv
// Pipelined, run-time programmable N-input Boolean function unit.
// Stage 1 registers a one-hot decode of sel_in together with a copy of the
// active mask; stage 2 OR-reduces decode & mask. The mask can be replaced in
// parallel (cfg_we/cfg_data) or shifted in serially, LSB first
// (cfg_shift_en/cfg_sdi); cfg_done pulses the cycle after a new mask lands.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, sel_in      : input transaction
//   cfg_we, cfg_data      : parallel mask write (wins over a serial shift)
//   cfg_shift_en, cfg_sdi : serial mask load, one bit per cycle
//   dec_out, dec_valid    : stage-1 one-hot decode
//   y, y_valid            : stage-2 function result
//   cfg_done              : one-cycle pulse when a new mask becomes active
//   mask_out              : active mask readback
module minterm_lut_decoder
  import minterm_lut_decoder_pkg::*;
#(
  parameter int          N         = 3,
  parameter logic [63:0] INIT_MASK = DEFAULT_MASK_N3,
  localparam int         W         = dec_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] sel_in,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_shift_en,
  input  logic         cfg_sdi,
  output logic [W-1:0] dec_out,
  output logic         dec_valid,
  output logic         y,
  output logic         y_valid,
  output logic         cfg_done,
  output logic [W-1:0] mask_out
);

  localparam int          CW         = cnt_width(N);
  localparam logic [W-1:0] MASK_RST  = INIT_MASK[W-1:0];
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  // Configuration state
  logic [W-1:0]  mask_q,   mask_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          done_q,   done_d;
  logic [W-1:0]  shift_val;

  // Pipeline state
  logic [W-1:0] dec_p1_q,  dec_p1_d;
  logic         vld_p1_q,  vld_p1_d;
  logic [W-1:0] mask_p1_q;
  logic         y_p2_q,    y_p2_d;
  logic         vld_p2_q,  vld_p2_d;

  // Mask configuration: parallel write has priority and also abandons any
  // partially shifted serial load.
  always_comb begin
    mask_d    = mask_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shift_val = {cfg_sdi, shadow_q[W-1:1]};
    if (cfg_we) begin
      mask_d   = cfg_data;
      shadow_d = '0;
      cnt_d    = '0;
      done_d   = 1'b1;
    end else if (cfg_shift_en) begin
      shadow_d = shift_val;
      // The final bit commits together with the rest of the shadow.
      if (cnt_q == LAST_BIT) begin
        mask_d = shift_val;
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= MASK_RST;
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // ---- stage 0 -> 1: decode and per-transaction mask snapshot ----
  decoder_n #(
    .N (N)
  ) u_dec (
    .en_i     (in_valid),
    .sel_i    (sel_in),
    .onehot_o (dec_p1_d)
  );

  assign vld_p1_d = in_valid;

  // The snapshot makes each transaction immune to later mask changes; it is
  // only meaningful while vld_p1_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mask_p1_q <= mask_q;
    end
  end

  // ---- stage 1 -> 2: OR-reduce decode against the snapshot ----
  assign y_p2_d   = vld_p1_q & (|(dec_p1_q & mask_p1_q));
  assign vld_p2_d = vld_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_p1_q <= '0;
      vld_p1_q <= 1'b0;
      y_p2_q   <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      dec_p1_q <= dec_p1_d;
      vld_p1_q <= vld_p1_d;
      y_p2_q   <= y_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign dec_out   = dec_p1_q;
  assign dec_valid = vld_p1_q;
  assign y         = y_p2_q;
  assign y_valid   = vld_p2_q;
  assign cfg_done  = done_q;
  assign mask_out  = mask_q;

endmodule

// File: tb/tb_minterm_lut_decoder.sv
// Bench for minterm_lut_decoder: directed tests on an N=3 instance plus a
// random run on N=1 and N=5 instances, all through per-cycle scoreboards.
module tb_minterm_lut_decoder;

  typedef struct {
    logic        v;
    logic        y;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // N=3 instance
  logic       in_valid, cfg_we, cfg_shift_en, cfg_sdi;
  logic [2:0] sel_in;
  logic [7:0] cfg_data, dec_out, mask_out;
  logic       dec_valid, y, y_valid, cfg_done;

  // N=1 instance (default mask truncated to 2 bits)
  logic       in_valid_a, cfg_we_a, cfg_shift_en_a, cfg_sdi_a;
  logic [0:0] sel_in_a;
  logic [1:0] cfg_data_a, dec_out_a, mask_out_a;
  logic       dec_valid_a, y_a, y_valid_a, cfg_done_a;

  // N=5 instance
  logic        in_valid_b, cfg_we_b, cfg_shift_en_b, cfg_sdi_b;
  logic [4:0]  sel_in_b;
  logic [31:0] cfg_data_b, dec_out_b, mask_out_b;
  logic        dec_valid_b, y_b, y_valid_b, cfg_done_b;

  minterm_lut_decoder #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel_in(sel_in),
    .cfg_we(cfg_we), .cfg_data(cfg_data), .cfg_shift_en(cfg_shift_en),
    .cfg_sdi(cfg_sdi), .dec_out(dec_out), .dec_valid(dec_valid), .y(y),
    .y_valid(y_valid), .cfg_done(cfg_done), .mask_out(mask_out)
  );

  minterm_lut_decoder #(.N(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .sel_in(sel_in_a),
    .cfg_we(cfg_we_a), .cfg_data(cfg_data_a), .cfg_shift_en(cfg_shift_en_a),
    .cfg_sdi(cfg_sdi_a), .dec_out(dec_out_a), .dec_valid(dec_valid_a), .y(y_a),
    .y_valid(y_valid_a), .cfg_done(cfg_done_a), .mask_out(mask_out_a)
  );

  minterm_lut_decoder #(.N(5), .INIT_MASK(64'hDEADBEEF)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .sel_in(sel_in_b),
    .cfg_we(cfg_we_b), .cfg_data(cfg_data_b), .cfg_shift_en(cfg_shift_en_b),
    .cfg_sdi(cfg_sdi_b), .dec_out(dec_out_b), .dec_valid(dec_valid_b), .y(y_b),
    .y_valid(y_valid_b), .cfg_done(cfg_done_b), .mask_out(mask_out_b)
  );

  // Scoreboards and reference state
  exp_t        sb3[$], sba[$], sbb[$];
  logic [63:0] m3, sh3, ma, sha, mb, shb;
  int          cn3, cna, cnb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference for mask configuration of a w-bit mask.
  task automatic cfg_model(input int w, input logic we, input logic [63:0] d,
                           input logic sh, input logic sdi,
                           inout logic [63:0] mask, inout logic [63:0] shadow,
                           inout int cnt, output logic done);
    logic [63:0] wm;
    wm   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    done = 1'b0;
    if (we) begin
      mask   = d & wm;
      shadow = '0;
      cnt    = 0;
      done   = 1'b1;
    end else if (sh) begin
      shadow = (shadow >> 1) | ({63'd0, sdi} << (w - 1));
      cnt++;
      if (cnt == w) begin
        mask = shadow;
        cnt  = 0;
        done = 1'b1;
      end
    end
  endtask

  task automatic reset_models();
    m3 = 64'h72;       sh3 = '0; cn3 = 0; sb3.delete();
    ma = 64'h2;        sha = '0; cna = 0; sba.delete();
    mb = 64'hDEADBEEF; shb = '0; cnb = 0; sbb.delete();
  endtask

  task automatic idle_inputs();
    in_valid = 0; sel_in = '0; cfg_we = 0; cfg_data = '0; cfg_shift_en = 0; cfg_sdi = 0;
    in_valid_a = 0; sel_in_a = '0; cfg_we_a = 0; cfg_data_a = '0; cfg_shift_en_a = 0; cfg_sdi_a = 0;
    in_valid_b = 0; sel_in_b = '0; cfg_we_b = 0; cfg_data_b = '0; cfg_shift_en_b = 0; cfg_sdi_b = 0;
  endtask

  // One clock of the N=3 instance: drive, predict, clock, compare.
  task automatic step3(input logic iv, input logic [2:0] s, input logic we,
                       input logic [7:0] d, input logic sh, input logic sdi);
    exp_t e, o;
    logic dn;
    in_valid = iv; sel_in = s; cfg_we = we; cfg_data = d; cfg_shift_en = sh; cfg_sdi = sdi;
    e.v = iv;
    e.d = iv ? (64'd1 << s) : 64'd0;
    e.y = iv & m3[s];
    sb3.push_back(e);
    cfg_model(8, we, {56'd0, d}, sh, sdi, m3, sh3, cn3, dn);
    @(posedge clk); #1;
    check("dec_valid", dec_valid, e.v);
    check("dec_out", dec_out, e.d);
    check("cfg_done", cfg_done, dn);
    check("mask_out", mask_out, m3);
    if (sb3.size() > 1) begin
      o = sb3.pop_front();
      check("y_valid", y_valid, o.v);
      check("y", y, o.y);
    end
  endtask

  task automatic idle3(input int n);
    for (int i = 0; i < n; i++) step3(0, 3'd0, 0, 8'd0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits;
    exp_t ea, eb, oa, ob;
    logic dna, dnb;

    idle_inputs();
    reset_models();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset defaults
    check("rst_dec_out", dec_out, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_mask", mask_out, 64'h72);
    check("rst_mask_n1", mask_out_a, 64'h2);
    check("rst_mask_n5", mask_out_b, 64'hDEADBEEF);

    // Default function, back-to-back
    for (int s = 0; s < 8; s++) step3(1, 3'(s), 0, 8'd0, 0, 0);
    idle3(2);

    // Parallel write, then sweep with gaps
    step3(0, 3'd0, 1, 8'h81, 0, 0);
    for (int s = 0; s < 8; s++) begin
      step3(1, 3'(s), 0, 8'd0, 0, 0);
      if (s % 3 == 1) idle3(1);
    end

    // Async reset mid-cycle with results in flight and a partial serial load
    step3(0, 3'd0, 1, 8'h96, 0, 0);
    step3(1, 3'd7, 0, 8'd0, 1, 1);
    step3(1, 3'd7, 0, 8'd0, 1, 0);
    step3(1, 3'd4, 0, 8'd0, 1, 1);
    #2 rst_n = 0;
    idle_inputs();
    #1;
    check("arst_dec_valid", dec_valid, 0);
    check("arst_dec_out", dec_out, 0);
    check("arst_y_valid", y_valid, 0);
    check("arst_y", y, 0);
    check("arst_mask", mask_out, 64'h72);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    reset_models();
    idle3(2);

    // Serial load of 'h81, LSB first
    bits = 8'h81;
    for (int i = 0; i < 8; i++) step3(0, 3'd0, 0, 8'd0, 1, bits[i]);
    for (int s = 0; s < 8; s++) step3(1, 3'(s), 0, 8'd0, 0, 0);

    // Partial serial load must leave the mask alone
    bits = 8'h1A;
    for (int i = 0; i < 5; i++) step3(1, 3'(i), 0, 8'd0, 1, bits[i]);
    idle3(3);

    // Mask change in the same cycle as an accepted input
    step3(0, 3'd0, 1, 8'h72, 0, 0);
    step3(1, 3'd1, 1, 8'h00, 0, 0);
    step3(1, 3'd1, 0, 8'd0, 0, 0);
    idle3(2);

    // Parallel write beats a simultaneous shift and restarts the counter
    step3(0, 3'd0, 0, 8'd0, 1, 1);
    step3(0, 3'd0, 1, 8'h5A, 1, 1);
    bits = 8'h3C;
    for (int i = 0; i < 8; i++) step3(1, 3'(i), 0, 8'd0, 1, bits[i]);
    for (int s = 0; s < 8; s++) step3(1, 3'(s), 0, 8'd0, 0, 0);
    idle3(2);

    // Random run on N=1 and N=5 instances
    for (int c = 0; c < 400; c++) begin
      in_valid_a     = ($urandom_range(0, 3) != 0);
      sel_in_a       = 1'($urandom);
      cfg_we_a       = ($urandom_range(0, 19) == 0);
      cfg_data_a     = 2'($urandom);
      cfg_shift_en_a = ($urandom_range(0, 3) == 0);
      cfg_sdi_a      = 1'($urandom);
      in_valid_b     = ($urandom_range(0, 2) != 0);
      sel_in_b       = 5'($urandom);
      cfg_we_b       = ($urandom_range(0, 29) == 0);
      cfg_data_b     = $urandom;
      cfg_shift_en_b = ($urandom_range(0, 1) == 0);
      cfg_sdi_b      = 1'($urandom);

      ea.v = in_valid_a;
      ea.d = in_valid_a ? (64'd1 << sel_in_a) : 64'd0;
      ea.y = in_valid_a & ma[sel_in_a];
      sba.push_back(ea);
      cfg_model(2, cfg_we_a, {62'd0, cfg_data_a}, cfg_shift_en_a, cfg_sdi_a, ma, sha, cna, dna);

      eb.v = in_valid_b;
      eb.d = in_valid_b ? (64'd1 << sel_in_b) : 64'd0;
      eb.y = in_valid_b & mb[sel_in_b];
      sbb.push_back(eb);
      cfg_model(32, cfg_we_b, {32'd0, cfg_data_b}, cfg_shift_en_b, cfg_sdi_b, mb, shb, cnb, dnb);

      @(posedge clk); #1;
      check("n1_dec_valid", dec_valid_a, ea.v);
      check("n1_dec_out", dec_out_a, ea.d);
      check("n1_cfg_done", cfg_done_a, dna);
      check("n1_mask", mask_out_a, ma);
      check("n5_dec_valid", dec_valid_b, eb.v);
      check("n5_dec_out", dec_out_b, eb.d);
      check("n5_cfg_done", cfg_done_b, dnb);
      check("n5_mask", mask_out_b, mb);
      if (sba.size() > 1) begin
        oa = sba.pop_front();
        check("n1_y_valid", y_valid_a, oa.v);
        check("n1_y", y_a, oa.y);
      end
      if (sbb.size() > 1) begin
        ob = sbb.pop_front();
        check("n5_y_valid", y_valid_b, ob.v);
        check("n5_y", y_b, ob.y);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
